// File: rtl/resp_burst_gen.sv
// Request/response burst responder: every request is answered with a burst of b beats starting the next cycle.
// Define RESP_BURST_GEN_PARITY_EN to add the registered b_par output.
module resp_burst_gen #(
   parameter int LEN_W = 4,
   parameter int ID_W  = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dis,
   input  logic             a,
   input  logic [LEN_W-1:0] a_len,
   input  logic [ID_W-1:0]  a_id,
   output logic             b,
   output logic [ID_W-1:0]  b_id,
   output logic             b_last,
   output logic             busy,
   output logic [CNT_W-1:0] resp_cnt,
   output logic [CNT_W-1:0] drop_cnt
`ifdef RESP_BURST_GEN_PARITY_EN
   ,
   output logic             b_par
`endif
);

   // state | meaning
   // IDLE  | no burst in flight, b low
   // BURST | emitting beats of the current burst; rem_q counts beats left including this one
   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t           state_q, state_n;
   logic [LEN_W-1:0] rem_q, rem_n;
   logic             pend_v_q, pend_v_n;
   logic [LEN_W-1:0] pend_len_q, pend_len_n;
   logic [ID_W-1:0]  pend_id_q, pend_id_n;
   logic [ID_W-1:0]  b_id_q, b_id_n;
   logic             busy_q;
   logic [CNT_W-1:0] resp_q, drop_q;
   logic             resp_inc, drop_inc;
   logic [LEN_W-1:0] a_len_eff;
   logic             last_beat;

   assign a_len_eff = (a_len == '0) ? LEN_W'(1) : a_len;
   assign last_beat = (state_q == BURST) && (rem_q == LEN_W'(1));

   always_comb begin
      state_n    = state_q;
      rem_n      = rem_q;
      pend_v_n   = pend_v_q;
      pend_len_n = pend_len_q;
      pend_id_n  = pend_id_q;
      b_id_n     = b_id_q;
      resp_inc   = 1'b0;
      drop_inc   = 1'b0;
      if (dis) begin
         state_n  = IDLE;
         rem_n    = '0;
         pend_v_n = 1'b0;
         b_id_n   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (a) begin
                  state_n = BURST;
                  rem_n   = a_len_eff;
                  b_id_n  = a_id;
               end
            end
            BURST: begin
               if (last_beat) begin
                  resp_inc = 1'b1;
                  if (pend_v_q) begin
                     // pending burst starts back-to-back; a new request refills the slot
                     rem_n      = pend_len_q;
                     b_id_n     = pend_id_q;
                     pend_v_n   = a;
                     pend_len_n = a ? a_len_eff : pend_len_q;
                     pend_id_n  = a ? a_id : pend_id_q;
                  end else if (a) begin
                     rem_n  = a_len_eff;
                     b_id_n = a_id;
                  end else begin
                     state_n = IDLE;
                     rem_n   = '0;
                     b_id_n  = '0;
                  end
               end else begin
                  rem_n = rem_q - LEN_W'(1);
                  if (a) begin
                     if (!pend_v_q) begin
                        pend_v_n   = 1'b1;
                        pend_len_n = a_len_eff;
                        pend_id_n  = a_id;
                     end else begin
                        drop_inc = 1'b1;
                     end
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         pend_v_q   <= 1'b0;
         pend_len_q <= '0;
         pend_id_q  <= '0;
         b_id_q     <= '0;
         busy_q     <= 1'b0;
         resp_q     <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_n;
         rem_q      <= rem_n;
         pend_v_q   <= pend_v_n;
         pend_len_q <= pend_len_n;
         pend_id_q  <= pend_id_n;
         b_id_q     <= b_id_n;
         busy_q     <= (state_n == BURST) || pend_v_n;
         if (resp_inc && (resp_q != '1)) resp_q <= resp_q + CNT_W'(1);
         if (drop_inc && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
      end
   end

`ifdef RESP_BURST_GEN_PARITY_EN
   logic par_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= (state_n == BURST) ? ^{b_id_n, (rem_n == LEN_W'(1))} : 1'b0;
   end
   assign b_par = par_q;
`endif

   assign b        = (state_q == BURST);
   assign b_last   = last_beat;
   assign b_id     = b_id_q;
   assign busy     = busy_q;
   assign resp_cnt = resp_q;
   assign drop_cnt = drop_q;

endmodule

// File: doc/resp_burst_gen.md
Name: resp_burst_gen

Overview:
- Responder side of the request/response protocol in which a request `a` is always answered by `b` starting the next cycle (a |=> b), with a synchronous disable that cancels responses (disable iff).
- Each request carries a length and an ID. The block emits a burst of `b` beats tagged with that ID.
- Holds one pending request while a burst is in flight and counts completed bursts and dropped requests.
- Sits opposite the protocol assertion checkers and drives `b` into them.

Parameters:
- LEN_W, 4, width of the request length field; max burst = 2^LEN_W-1 beats.
- ID_W, 4, width of the request/response ID.
- CNT_W, 8, width of the saturating statistics counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dis  in  1  synchronous disable/abort; highest priority after reset.
- a  in  1  request strobe, one cycle per request.
- a_len  in  LEN_W  burst length; 0 is treated as 1.
- a_id  in  ID_W  request ID.
- b  out  1  response beat valid (registered).
- b_id  out  ID_W  ID of the burst currently output.
- b_last  out  1  final beat of the current burst.
- busy  out  1  burst in flight or pending request held (registered).
- resp_cnt  out  CNT_W  completed bursts, saturating.
- drop_cnt  out  CNT_W  dropped requests, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, pending cleared. b, b_id, b_last, busy, resp_cnt and drop_cnt are all 0 immediately. Release is synchronous to clk.
- FSM states: IDLE and BURST. Internal registers: remaining-beat counter (LEN_W bits) and pending slot {valid, len, id}.
- IDLE with a=1:
  - Next cycle: state BURST, b=1, b_id=a_id, remaining=max(a_len,1).
  - b_last=1 when the effective length is 1.
  - Latency request→first beat is exactly 1 cycle.
- BURST, each cycle:
  - b=1; remaining decrements once per beat.
  - b_last=1 on the final beat only.
- BURST, on the cycle b_last=1, the next-edge action is chosen in priority order:
  1. Pending valid: start the pending burst back-to-back with no gap and clear pending. If a=1 in the same cycle, that request fills pending.
  2. Else a=1: start the new burst with no gap.
  3. Else: go to IDLE, so b=0 next cycle.
- BURST, a=1 on a non-last beat:
  - Pending empty: capture {len, id} into pending.
  - Pending full: drop the request, drop_cnt+1 (saturate at 2^CNT_W-1).
- resp_cnt increments once per completed burst, at the edge where b_last=1 and b=1. It saturates.
- Consequence: with dis=0, every cycle with a=1 is followed by b=1 the next cycle (a |=> b holds), including while busy.
- dis=1 at an edge:
  - State goes to IDLE; pending and remaining are cleared.
  - b, b_last and b_id are 0 next cycle.
  - An a in the same cycle is ignored and not counted as dropped.
  - A burst cut short does not increment resp_cnt.
  - Counters keep their values.
- busy = (next state == BURST) or (next pending valid), registered.
- Widths:
  - Remaining counter never wraps: it is reloaded or the FSM leaves BURST when it reaches 1.
  - Counters saturate and never wrap.

Optional Feature:
- RESP_BURST_GEN_PARITY_EN defined:
  - Adds output port b_par (1 bit, registered) = XOR over {b_id, b_last} when b=1, else 0.
  - b_par resets to 0.
- Macro undefined: the b_par port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single beat: after reset, a=1, a_len=1, a_id=5 at cycle 0 → cycle 1: b=1, b_id=5, b_last=1. Cycle 2: b=0, busy=0, resp_cnt=1.
- Back-to-back via pending: cycle 0 a_len=3, a_id=2; cycle 1 a_len=2, a_id=7 → b=1 in cycles 1–5 with b_id 2,2,2,7,7. b_last in cycles 3 and 5. resp_cnt=2, drop_cnt=0.
- Overflow: cycle 0 a_len=4; a=1 in cycles 1 and 2 → second extra request dropped, drop_cnt=1. Bursts run in cycles 1–4 then 5 onward, with no gap.
- Disable:
  - a_len=5 at cycle 0, dis=1 in cycle 2 → b=0 from cycle 3, busy=0, resp_cnt=0.
  - dis=1 together with a=1 → no b next cycle, drop_cnt unchanged.
- Zero length and saturation: a_len=0 → exactly one beat with b_last=1. 300 single-beat requests with CNT_W=8 → resp_cnt=255.
- Async reset mid-burst: rst_n=0 between clock edges during a 5-beat burst → b, busy and counters are 0 immediately. After release, a fresh a gives b next cycle.
